// File: rtl/pixel_write_master_if.sv
// rtl/pixel_write_master_if.sv - pixel stream and Avalon-MM bus bundle for pixel_write_master
//
// Purpose: groups the pixel valid/ready stream and the Avalon-MM initiator
// signals of pixel_write_master into one bundle.
// Modports:
//   master - view of pixel_write_master: consumes the pixel stream, drives the bus
//   slave  - view of the environment: pixel source plus Avalon-MM target
// Signals:
//   pix_data[23:0], pix_valid, pix_ready        pixel stream {R,G,B}
//   avm_address[ADDR_W-1:0], avm_chipselect,
//   avm_write_n, avm_read_n, avm_writedata[31:0] initiator outputs
//   avm_readdata[31:0], avm_waitrequest          target responses
interface pixel_write_master_if #(
  parameter int ADDR_W = 2
);
  logic [23:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  pix_data, pix_valid,
    output pix_ready,
    output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    output pix_data, pix_valid,
    input  pix_ready,
    input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/pixel_write_master.sv
// rtl/pixel_write_master.sv - Avalon-MM initiator writing buffered RGB pixels to a fixed register
//
// Purpose: accepts 24-bit pixels on a valid/ready stream, buffers them in a
// 2^FIFO_AW entry FIFO and issues one single-word Avalon-MM write per pixel to
// TARGET_ADDR, honouring waitrequest.
// Build option: define PIXEL_READBACK_EN to follow every write with a verifying
// read; a mismatch sets the sticky error flag. Without it avm_read_n stays 1,
// error stays 0 and err_clr is ignored.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   bus (master)     pixel stream in, Avalon-MM initiator out
//   busy             FIFO non-empty or transaction in flight
//   wr_count[15:0]   completed writes, wrapping
//   err_clr          clears error (readback build only)
//   error            sticky readback mismatch (readback build only)
module pixel_write_master #(
  parameter int ADDR_W      = 2,
  parameter int TARGET_ADDR = 0,
  parameter int FIFO_AW     = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  pixel_write_master_if.master        bus,
  output logic                        busy,
  output logic [15:0]                 wr_count,
  input  logic                        err_clr,
  output logic                        error
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] LVL_ZERO = '0;

`ifdef PIXEL_READBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_WRITE} state_t;
`endif

  state_t r_state;
  state_t w_next_state;

  logic [23:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_pix_ready;

  logic               r_cs;
  logic               r_write_n;
  logic [31:0]        r_writedata;
  logic [15:0]        r_wr_count;

  logic               w_push;
  logic               w_pop;
  logic [FIFO_AW:0]   w_level_next;
  logic [FIFO_AW-1:0] w_rptr_inc;
  logic [23:0]        w_head_next;

  assign w_push       = bus.pix_valid & r_pix_ready;
  assign w_pop        = (r_state == S_WRITE) & ~bus.avm_waitrequest;
  assign w_level_next = r_level + (FIFO_AW + 1)'(w_push) - (FIFO_AW + 1)'(w_pop);
  assign w_rptr_inc   = r_rptr + FIFO_AW'(1);

  // Entry presented on the next write: the one after the head when this cycle
  // pops it, else the current head. Both slots are already filled whenever the
  // FSM chooses WRITE, so a same-cycle push is never needed here.
  assign w_head_next = w_pop ? r_mem[w_rptr_inc] : r_mem[r_rptr];

  // FIFO storage; no reset needed, validity is tracked by r_level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.pix_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_pix_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= w_rptr_inc;
      r_level     <= w_level_next;
      // Registered from the next level, so a pop while full only reopens
      // the input one cycle later.
      r_pix_ready <= (w_level_next != LVL_FULL);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_level != LVL_ZERO) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (!bus.avm_waitrequest) begin
`ifdef PIXEL_READBACK_EN
          w_next_state = S_READ;
`else
          // Stay only if an entry other than the one being popped exists.
          w_next_state = (r_level > LVL_ONE) ? S_WRITE : S_IDLE;
`endif
        end
      end
`ifdef PIXEL_READBACK_EN
      S_READ: begin
        if (!bus.avm_waitrequest) begin
          w_next_state = (r_level != LVL_ZERO) ? S_WRITE : S_IDLE;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state, so they change together
  // with the state and never depend combinationally on waitrequest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs        <= 1'b0;
      r_write_n   <= 1'b1;
      r_writedata <= '0;
      r_wr_count  <= '0;
    end else begin
      r_cs      <= (w_next_state != S_IDLE);
      r_write_n <= (w_next_state != S_WRITE);
      if (w_next_state == S_WRITE) begin
        r_writedata <= {8'h00, w_head_next};
      end
      if (w_pop) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign bus.pix_ready      = r_pix_ready;
  assign bus.avm_address    = ADDR_W'(TARGET_ADDR);
  assign bus.avm_chipselect = r_cs;
  assign bus.avm_write_n    = r_write_n;
  assign bus.avm_writedata  = r_writedata;
  assign wr_count           = r_wr_count;
  assign busy               = (r_state != S_IDLE) | (r_level != LVL_ZERO);

`ifdef PIXEL_READBACK_EN
  logic r_read_n;
  logic r_error;
  logic w_mismatch;

  // r_writedata still holds the last written word during READ, and its top
  // byte is zero, so one 32-bit compare covers both pixel and pad byte.
  assign w_mismatch = (r_state == S_READ) & ~bus.avm_waitrequest &
                      (bus.avm_readdata != r_writedata);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_n <= 1'b1;
      r_error  <= 1'b0;
    end else begin
      r_read_n <= (w_next_state != S_READ);
      if (w_mismatch) begin
        r_error <= 1'b1;
      end else if (err_clr) begin
        r_error <= 1'b0;
      end
    end
  end

  assign bus.avm_read_n = r_read_n;
  assign error          = r_error;
`else
  logic w_unused;
  assign w_unused       = err_clr ^ (^bus.avm_readdata);
  assign bus.avm_read_n = 1'b1;
  assign error          = 1'b0;
`endif
endmodule

// File: doc/pixel_write_master.md
Name: pixel_write_master

Overview:
- Avalon-MM initiator: the driving end of the pixel-data output-port slave.
- Accepts a 24-bit RGB pixel stream through a valid/ready handshake and buffers it in a small FIFO.
- Issues one single-word write per pixel to a fixed slave address, honouring waitrequest.
- Sits between the image source (ROM/decoder) and the pixel-data port, replacing CPU-driven pixel writes.

Parameters:
- ADDR_W, 2: width of avm_address.
- TARGET_ADDR, 0: word address of the pixel-data register; driven on every transaction.
- FIFO_AW, 2: log2 of FIFO depth (default depth 4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_data  in  24  pixel {R,G,B}
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  FIFO can accept a pixel
- avm_address  out  ADDR_W  slave word address
- avm_chipselect  out  1  transaction active
- avm_write_n  out  1  active-low write strobe
- avm_read_n  out  1  active-low read strobe (readback only)
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- busy  out  1  FIFO non-empty or transaction in flight
- wr_count  out  16  completed writes, wrapping
- err_clr  in  1  clears error
- error  out  1  sticky readback mismatch

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied; FSM to IDLE; wr_count=0; error=0.
  - avm_chipselect=0, avm_write_n=1, avm_read_n=1, avm_address=TARGET_ADDR, avm_writedata=0.
  - pix_ready=0 while reset_n=0; pix_ready=1 from the first clk after release.
  - Reset mid-transaction aborts it immediately; the pixel is lost and not counted.
- Push: pix_valid & pix_ready at a clk edge writes pix_data to the FIFO.
  - pix_ready = !full, registered-state based.
  - While full, pix_ready=0 even if a pop occurs the same cycle; the pop frees the slot for the next cycle.
  - A pixel offered while pix_ready=0 is not taken; the source holds it.
- FIFO: depth 2^FIFO_AW; pointers wrap modulo depth. Simultaneous push and pop when non-empty and non-full leaves the level unchanged.
- FSM states:
  - IDLE:
    - All strobes inactive.
    - FIFO non-empty -> WRITE, driving the head entry the next cycle. Latency from push to avm_write_n=0 is 2 clks.
  - WRITE:
    - Drives avm_chipselect=1, avm_write_n=0, avm_address=TARGET_ADDR, avm_writedata={8'h00, head}.
    - All signals held stable while avm_waitrequest=1.
    - When avm_waitrequest=0 at a clk edge: accepted, pop, wr_count+1 (0xFFFF->0x0000).
    - After acceptance: READ if PIXEL_READBACK_EN is defined; else WRITE again if the FIFO still holds another entry (back-to-back, one write per clk at zero wait); else IDLE.
  - READ (macro only):
    - Drives avm_chipselect=1, avm_read_n=0, avm_write_n=1, avm_address=TARGET_ADDR.
    - Holds while avm_waitrequest=1.
    - On the edge where avm_waitrequest=0: samples avm_readdata. Sets error if readdata[23:0] != the last written pixel or readdata[31:24] != 0.
    - Next state: WRITE if FIFO non-empty, else IDLE.
- avm_write_n and avm_read_n are never both 0.
- avm_chipselect=0 in IDLE.
- Outputs are registered. Default strobes are inactive (avm_write_n/avm_read_n=1, avm_chipselect=0). No combinational path from avm_waitrequest to any output.
- error:
  - Sticky.
  - err_clr=1 clears it at the next edge.
  - A mismatch in the same cycle as err_clr wins: error=1.
- busy = (state != IDLE) | FIFO non-empty.

Optional Feature:
- PIXEL_READBACK_EN
- Defined:
  - READ state present; every write is followed by a verifying read.
  - Throughput is at most one pixel per 2 clks at zero wait.
- Undefined:
  - READ state and compare logic absent.
  - avm_read_n tied to 1; error tied to 0; err_clr ignored.

Test Plan:
- Reset, then push 0x123456 with avm_waitrequest=0 -> 2 clks later one cycle of avm_chipselect=1, avm_write_n=0, avm_writedata=0x00123456, avm_address=0; wr_count=1; busy returns to 0.
- Push 4 pixels (0x000001..0x000004) in consecutive clks with avm_waitrequest=1 -> pix_ready=0 after the 4th push; writedata held at 0x00000001. Release waitrequest -> 4 back-to-back writes in order; wr_count=4.
- Stall 3 clks on one write -> address, writedata and strobes unchanged across all 3 clks; exactly one pop and one count increment.
- Preload wr_count to 0xFFFF via 65535 writes, then one more -> wr_count=0x0000.
- Assert reset_n=0 mid-stall with 2 pixels buffered -> strobes go inactive immediately, FIFO empty, wr_count=0. After release, no write is issued.
- With PIXEL_READBACK_EN, write 0xABCDEF, return readdata 0x00ABCDEE -> error=1 and stays 1 across later good reads. Pulse err_clr -> error=0. Return 0x00ABCDEF -> error remains 0.
